alu_sequencer: RTL and testbench

//  Multi-cycle control unit around the 8-bit ALU: fetches 16-bit instructions, drives register-file read/write addresses and ALU op/immediates, writes results back, updates PC (incl. ALU jumps).

---
 rtl/alu_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Purpose  : Multi-cycle fetch/decode/execute/write-back controller for the
//             8-bit ALU, register file, instruction memory and board I/O.
//  Revision : 1.0  initial release
// ============================================================================
module alu_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int RESET_PC    = 0,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   run,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic                   imem_rd,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [2:0]             rf_ra1,
    output logic [2:0]             rf_ra2,
    output logic [2:0]             rf_wa,
    output logic                   rf_we,
    output logic [7:0]             rf_wd,
    output logic [4:0]             alu_op,
    output logic [2:0]             alu_im,
    output logic [7:0]             alu_im8,
    input  logic [7:0]             alu_res,
    input  logic                   alu_jmp,
    input  logic                   dip_valid,
    output logic                   dip_ack,
    output logic                   show_strobe,
    output logic [7:0]             show_data,
    output logic                   illegal,
    output logic [15:0]            retired,
    output logic                   busy
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;

    localparam logic [4:0] c_OP_NOP    = 5'b00000;

    logic [2:0]             r_state;
    logic [2:0]             w_state_next;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [INSTR_WIDTH-1:0] r_ir;
    logic [7:0]             r_res_q;
    logic                   r_jmp_q;
    logic [7:0]             r_show_data;
    logic [15:0]            r_retired;

    logic [4:0] w_op;
    logic       w_op_illegal;
    logic       w_op_write;
    logic       w_op_show;
    logic       w_op_dip;
    logic       w_exec_done;

    assign w_op = r_ir[15:11];

    always_comb begin
        w_op_illegal = 1'b0;
        w_op_write   = 1'b0;
        w_op_show    = 1'b0;
        w_op_dip     = 1'b0;
        case (w_op)
            5'b10001, 5'b10010, 5'b10111: w_op_illegal = 1'b1;
            5'b10011, 5'b11111:           w_op_show    = 1'b1;
            default: ;
        endcase
        if ((w_op >= 5'd1 && w_op <= 5'd6) || (w_op >= 5'd8 && w_op <= 5'd16) ||
            w_op == 5'b10100 || w_op == 5'b10101 || w_op == 5'b11110)
            w_op_write = 1'b1;
        if (w_op == 5'b10100 || w_op == 5'b10101)
            w_op_dip = 1'b1;
    end

    // A DIP load parks in EXEC until the switch data is ready.
    assign w_exec_done = !w_op_dip || dip_valid;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (run) w_state_next = c_ST_FETCH;
            c_ST_FETCH:  w_state_next = c_ST_DECODE;
            c_ST_DECODE: w_state_next = c_ST_EXEC;
            c_ST_EXEC:   if (w_exec_done) w_state_next = c_ST_WB;
            c_ST_WB:     w_state_next = run ? c_ST_FETCH : c_ST_IDLE;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= c_ST_IDLE;
            r_pc        <= PC_WIDTH'(RESET_PC);
            r_ir        <= '0;
            r_res_q     <= '0;
            r_jmp_q     <= 1'b0;
            r_show_data <= '0;
            r_retired   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == c_ST_DECODE)
                r_ir <= imem_data;
            if (r_state == c_ST_EXEC && w_exec_done) begin
                r_res_q <= alu_res;
                r_jmp_q <= alu_jmp && !w_op_illegal;
            end
            if (r_state == c_ST_WB) begin
                r_pc      <= r_jmp_q ? PC_WIDTH'(r_res_q) : r_pc + 1'b1;
                r_retired <= r_retired + 16'd1;
                if (w_op_show)
                    r_show_data <= r_res_q;
            end
        end
    end

    always_comb begin
        imem_rd     = 1'b0;
        rf_ra1      = 3'd0;
        rf_ra2      = 3'd0;
        rf_wa       = 3'd0;
        rf_we       = 1'b0;
        rf_wd       = 8'd0;
        alu_op      = c_OP_NOP;
        alu_im      = 3'd0;
        alu_im8     = 8'd0;
        dip_ack     = 1'b0;
        show_strobe = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            c_ST_FETCH: imem_rd = 1'b1;
            c_ST_EXEC: begin
                alu_op  = w_op_illegal ? c_OP_NOP : w_op;
                alu_im  = r_ir[4:2];
                alu_im8 = r_ir[7:0];
                rf_ra1  = r_ir[10:8];
                rf_ra2  = r_ir[7:5];
                dip_ack = w_op_dip && dip_valid;
            end
            c_ST_WB: begin
                rf_we       = w_op_write;
                rf_wa       = w_op_write ? r_ir[10:8] : 3'd0;
                rf_wd       = w_op_write ? r_res_q : 8'd0;
                show_strobe = w_op_show;
                illegal     = w_op_illegal;
            end
            default: ;
        endcase
    end

    assign imem_addr = r_pc;
    assign show_data = r_show_data;
    assign retired   = r_retired;
    assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_sequencer
//  Purpose  : Directed self-checking bench for alu_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        run;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data = 16'h0000;
    logic [2:0]  rf_ra1, rf_ra2, rf_wa;
    logic        rf_we;
    logic [7:0]  rf_wd;
    logic [4:0]  alu_op;
    logic [2:0]  alu_im;
    logic [7:0]  alu_im8;
    logic [7:0]  alu_res;
    logic        alu_jmp;
    logic        dip_valid;
    logic        dip_ack;
    logic        show_strobe;
    logic [7:0]  show_data;
    logic        illegal;
    logic [15:0] retired;
    logic        busy;

    logic [15:0] imem [0:255];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    always @(posedge clock)
        if (imem_rd) imem_data <= imem[imem_addr];

    alu_sequencer #(.PC_WIDTH(8), .RESET_PC(0), .INSTR_WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n), .run(run),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa), .rf_we(rf_we), .rf_wd(rf_wd),
        .alu_op(alu_op), .alu_im(alu_im), .alu_im8(alu_im8),
        .alu_res(alu_res), .alu_jmp(alu_jmp),
        .dip_valid(dip_valid), .dip_ack(dip_ack),
        .show_strobe(show_strobe), .show_data(show_data),
        .illegal(illegal), .retired(retired), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one instruction starting in FETCH and ends in the following FETCH.
    task automatic exec_instr(input string name, input logic [4:0] exp_op,
                              input logic [7:0] res, input logic jmp,
                              input logic exp_we, input logic [2:0] exp_wa,
                              input logic exp_show, input logic exp_ill,
                              input logic [7:0] exp_next);
        chk({name, ".fetch_rd"}, imem_rd, 1);
        tick();
        chk({name, ".decode_op"}, alu_op, 0);
        tick();
        chk({name, ".exec_op"}, alu_op, exp_op);
        alu_res = res;
        alu_jmp = jmp;
        tick();
        chk({name, ".wb_we"}, rf_we, exp_we);
        if (exp_we) begin
            chk({name, ".wb_wa"}, rf_wa, exp_wa);
            chk({name, ".wb_wd"}, rf_wd, res);
        end
        chk({name, ".wb_show"}, show_strobe, exp_show);
        chk({name, ".wb_illegal"}, illegal, exp_ill);
        chk({name, ".wb_op"}, alu_op, 0);
        alu_res = 8'h00;
        alu_jmp = 1'b0;
        tick();
        chk({name, ".next_pc"}, imem_addr, exp_next);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        imem[8'h00] = 16'h0940;  // ADD r1,r2
        imem[8'h01] = 16'h0000;  // NOP
        imem[8'h02] = 16'hB800;  // undefined 10111
        imem[8'h03] = 16'hE810;  // JMP 0x10
        imem[8'h10] = 16'hB123;  // CMP
        imem[8'h11] = 16'hC020;  // JE 0x20 (not taken)
        imem[8'h12] = 16'hC030;  // JE 0x30 (taken)
        imem[8'h30] = 16'h9A00;  // SHOW
        imem[8'h31] = 16'hA300;  // DIP load r3
        imem[8'h32] = 16'hE8FF;  // JMP 0xFF
        imem[8'hFF] = 16'h0A40;  // ADD r2,r2

        reset_n = 1'b0; run = 1'b0; alu_res = 8'h00; alu_jmp = 1'b0; dip_valid = 1'b0;
        tick();
        tick();
        chk("rst.busy", busy, 0);
        chk("rst.pc", imem_addr, 0);
        chk("rst.retired", retired, 0);
        chk("rst.rf_we", rf_we, 0);
        chk("rst.alu_op", alu_op, 0);
        chk("rst.show_data", show_data, 0);

        // ADD from IDLE: write-back lands in the fifth cycle
        reset_n = 1'b1; run = 1'b1;
        chk("add.idle", busy, 0);
        tick();
        chk("add.fetch_rd", imem_rd, 1);
        chk("add.fetch_addr", imem_addr, 0);
        tick();
        chk("add.decode_op", alu_op, 0);
        tick();
        chk("add.exec_op", alu_op, 5'b00001);
        chk("add.ra1", rf_ra1, 1);
        chk("add.ra2", rf_ra2, 2);
        alu_res = 8'h2A;
        tick();
        chk("add.wb_we", rf_we, 1);
        chk("add.wb_wa", rf_wa, 1);
        chk("add.wb_wd", rf_wd, 8'h2A);
        alu_res = 8'h00;
        tick();
        chk("add.pc", imem_addr, 1);
        chk("add.retired", retired, 1);

        exec_instr("nop",  5'b00000, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h02);
        exec_instr("ill",  5'b00000, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h03);
        exec_instr("jmp",  5'b11101, 8'h10, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h10);
        exec_instr("cmp",  5'b10110, 8'h99, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h11);
        exec_instr("je_n", 5'b11000, 8'h20, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h12);
        exec_instr("je_t", 5'b11000, 8'h30, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h30);
        exec_instr("show", 5'b10011, 8'h55, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h31);
        chk("show.data", show_data, 8'h55);

        // DIP load stalls in EXEC until dip_valid
        chk("dip.fetch_rd", imem_rd, 1);
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("dip.stall_op", alu_op, 5'b10100);
            chk("dip.stall_ack", dip_ack, 0);
            chk("dip.stall_busy", busy, 1);
            tick();
        end
        dip_valid = 1'b1;
        alu_res   = 8'h77;
        #1;
        chk("dip.ack", dip_ack, 1);
        chk("dip.ack_we", rf_we, 0);
        tick();
        dip_valid = 1'b0;
        alu_res   = 8'h00;
        chk("dip.wb_ack", dip_ack, 0);
        chk("dip.wb_we", rf_we, 1);
        chk("dip.wb_wa", rf_wa, 3);
        chk("dip.wb_wd", rf_wd, 8'h77);
        tick();
        chk("dip.pc", imem_addr, 8'h32);

        exec_instr("jmpff", 5'b11101, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'hFF);
        exec_instr("wrap",  5'b00001, 8'h01, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h00);
        chk("wrap.retired", retired, 11);
        chk("wrap.show_hold", show_data, 8'h55);

        // Reset while in WB
        tick();
        tick();
        alu_res = 8'h05;
        tick();
        chk("rstwb.we_before", rf_we, 1);
        reset_n = 1'b0;
        alu_res = 8'h00;
        tick();
        chk("rstwb.busy", busy, 0);
        chk("rstwb.pc", imem_addr, 0);
        chk("rstwb.we", rf_we, 0);
        chk("rstwb.show_strobe", show_strobe, 0);
        chk("rstwb.retired", retired, 0);
        chk("rstwb.show_data", show_data, 0);

        // Reset during a DIP stall
        imem[8'h00] = 16'hA300;
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        chk("rstdip.op", alu_op, 5'b10100);
        tick();
        chk("rstdip.still", alu_op, 5'b10100);
        reset_n = 1'b0;
        run     = 1'b0;
        tick();
        chk("rstdip.busy", busy, 0);
        chk("rstdip.ack", dip_ack, 0);
        chk("rstdip.we", rf_we, 0);
        chk("rstdip.pc", imem_addr, 0);
        chk("rstdip.op0", alu_op, 0);

        // run dropped during DECODE: instruction still retires
        imem[8'h00] = 16'h0940;
        reset_n = 1'b1;
        run     = 1'b1;
        tick();
        tick();
        run = 1'b0;
        tick();
        alu_res = 8'h2A;
        tick();
        chk("stop.wb_we", rf_we, 1);
        chk("stop.wb_busy", busy, 1);
        alu_res = 8'h00;
        tick();
        chk("stop.busy", busy, 0);
        chk("stop.pc", imem_addr, 1);
        chk("stop.retired", retired, 1);
        tick();
        chk("stop.idle_hold", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
